// File: rtl/if_id_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_id_fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register for a 32-bit MIPS-style
// datapath. It holds the fetch PC and a word-addressed instruction memory. It
// latches the fetched word into IF/ID and splits that word into decode fields.
//
// Optional feature: define IF_ID_PERF_CNT_EN to add the fetch_count and
// stall_count performance counters.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-high reset (highest priority)
//   stall        hold PC and IF/ID contents
//   flush        replace IF/ID contents with a bubble
//   redirect     load PC from redirect_pc (taken branch/jump); also bubbles IF/ID
//   redirect_pc  branch/jump target; bits [1:0] ignored
//   load_en      instruction-memory write strobe; also stalls the pipe
//   load_addr    word index to write
//   load_data    instruction word to write
//   pc           current fetch PC
//   id_valid     IF/ID holds a real instruction
//   id_instr     latched instruction (0 when bubble)
//   id_pc_plus4  PC+4 of the latched instruction
//   id_opcode .. id_jaddr   pure bit slices of id_instr
//   fetch_count  (IF_ID_PERF_CNT_EN) edges on which IF/ID loaded a valid instr
//   stall_count  (IF_ID_PERF_CNT_EN) edges with stall=1 outside reset
// -----------------------------------------------------------------------------
module if_id_fetch_stage #(
  parameter int          IMEM_WORDS = 256,
  parameter int          IMEM_AW    = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               load_en,
  input  logic [IMEM_AW-1:0] load_addr,
  input  logic [31:0]        load_data,
  output logic [31:0]        pc,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc_plus4,
  output logic [5:0]         id_opcode,
  output logic [4:0]         id_rs,
  output logic [4:0]         id_rt,
  output logic [4:0]         id_rd,
  output logic [4:0]         id_shamt,
  output logic [5:0]         id_funct,
  output logic [15:0]        id_imm16,
  output logic [25:0]        id_jaddr
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  // ---------------------------------------------------------------------------
  // Instruction memory
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [IMEM_WORDS];

  // NOTE: the memory has no reset on purpose. Clearing a RAM would need a
  // multi-cycle sweep, and a program loaded before reset must survive it. This
  // also lets a write issued in the reset cycle still land.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  logic [IMEM_AW-1:0] fetch_idx;
  logic [31:0]        fetch_word;
  logic [31:0]        pc_plus4;
  logic               hold;
  logic               bubble;
  logic               fetch_en;

  // Upper PC bits are dropped, so fetch addresses wrap modulo IMEM_WORDS. The
  // read is asynchronous. A write in the same cycle lands only at the edge,
  // so the read still returns the old word.
  assign fetch_idx  = pc_q[IMEM_AW+1:2];
  assign fetch_word = mem_q[fetch_idx];
  assign pc_plus4   = pc_q + 32'd4;  // wraps FFFF_FFFC -> 0 naturally

  // A program-load cycle behaves like a hazard stall for the pipe.
  assign hold     = stall | load_en;
  assign bubble   = flush | redirect;
  assign fetch_en = ~bubble & ~hold;

  // NOTE: every always_comb output gets a default first. No path can then
  // leave a signal unassigned, so no latch can be inferred.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      // Redirect overrides stall/load: a taken branch must not be lost.
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (!hold) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (bubble) begin
      valid_d = 1'b0;
      instr_d = 32'h0;
      pc4_d   = 32'h0;
    end else if (!hold) begin
      valid_d = 1'b1;
      instr_d = fetch_word;
      pc4_d   = pc_plus4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples the pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (fetch_en) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  // Without the counters, fetch_en is not consumed anywhere.
  logic unused_fetch_en;
  assign unused_fetch_en = fetch_en;
`endif

  // Target alignment bits are deliberately discarded.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Outputs: decode fields are pure slices of the latched word
  // ---------------------------------------------------------------------------
  assign pc          = pc_q;
  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = pc4_q;
  assign id_opcode   = instr_q[31:26];
  assign id_rs       = instr_q[25:21];
  assign id_rt       = instr_q[20:16];
  assign id_rd       = instr_q[15:11];
  assign id_shamt    = instr_q[10:6];
  assign id_funct    = instr_q[5:0];
  assign id_imm16    = instr_q[15:0];
  assign id_jaddr    = instr_q[25:0];

endmodule
